starfield_ramp_ctrl: RTL
========================

# starfield_ramp_ctrl

Starfield motion controller between the CPU write bus and the starfield's register port (addr/data_in/write). The CPU writes target velocities and a ramp rate. Once per frame, on the vblank rising edge, the block steps each axis's current velocity toward its target. It then issues the byte writes the starfield needs, and passes CPU enable writes through when the port is free.

## Interface
- `RAMP_RST`, 8'd16: ramp step per frame after reset (speed units).
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `vblank`  in  1  vertical blank, level
- `cpu_addr`  in  3  CPU register select
- `cpu_data`  in  8  CPU write data
- `cpu_write`  in  1  CPU write strobe, one cycle per write
- `sf_addr`  out  3  starfield register address
- `sf_data`  out  8  starfield write data
- `sf_write`  out  1  starfield write strobe
- `busy`  out  1  update sequence in progress

## Operation
- CPU map:
  - 0 = enable byte, forwarded unchanged to starfield addr 0.
  - 1 = target H {dir, spd[14:8]}.
  - 2 = target H spd[7:0]; commits the H target from the staged byte 1.
  - 3 and 4 = same for V.
  - 5 = ramp step.
  - 6 = ctrl: bit0 hold (freeze ramping), bit1 snap (step treated as infinite).
  - 7 = ignored.
- Velocity is held internally as signed 16-bit: v = dir ? +spd : −spd. Range −32767..+32767.
- Per frame, per axis:
  - If |target − current| ≤ step, or snap is set, then current = target.
  - Otherwise current moves by step toward target.
  - Step 0 means no motion unless snap is set.
  - Arithmetic uses a 17-bit intermediate; no wrap.
- Conversion back to the port: dir = (current ≥ 0); spd = |current|[14:0]. Zero is sent as dir 1, spd 0.
- An axis is rewritten only if its converted value differs from the value last sent.
- FSM states: IDLE, CALC, WR_H1, WR_H2, WR_V1, WR_V2.
  - IDLE → CALC on a pending frame tick, if hold is 0.
  - CALC computes both axes (1 cycle).
  - CALC → WR_H1 if H changed, else WR_V1 if V changed, else IDLE.
  - WR_H1 → WR_H2 → (WR_V1 if V changed, else IDLE); WR_V1 → WR_V2 → IDLE.
  - Each WR state drives exactly one sf_write cycle. H1 and V1 send {dir, spd[14:8]} to addr 1/3; H2 and V2 send spd[7:0] to addr 2/4.
- Frame tick comes from a registered rising edge of vblank.
  - A tick arriving outside IDLE sets a one-deep pending flag; further ticks are merged.
  - With hold = 1, ticks are dropped, not queued.
- CPU enable pass-through:
  - A write to addr 0 latches a one-deep pending enable; a later write overwrites it.
  - It is issued on the first cycle the FSM is in IDLE or CALC.
  - It wins over CALC-to-WR: the FSM stalls one cycle in CALC.
- CPU writes to addresses 1–6 during a sequence update only the shadow registers. In-flight writes use the values latched at CALC.

## Timing
- Reset values:
  - All outputs 0.
  - Targets, current values, last-sent values and ctrl are 0.
  - Step = RAMP_RST; pending flags clear.
- Reset may assert in any state. The FSM returns to IDLE immediately, and any partial byte pair is abandoned.
- Output registers: sf_* are registered.
- Enable write latency:
  - cpu_write on addr 0 at cycle N gives sf_write at N+1 when idle.
  - It is delayed to the first cycle after the FSM reaches IDLE or CALC otherwise.
- Full update latency: vblank rises at N; tick registered at N+1; CALC at N+2; sf_write at N+3..N+6 (both axes changed).
- busy is high from CALC through the last WR state.

## Structure
- Shared package `starfield_pkg`: CPU and starfield address constants, FSM state enum, velocity width (16).
- Submodule `starfield_axis_ramp`, instantiated twice (H, V):
  - Inputs: target, current, step, snap.
  - Outputs: next current, {dir, spd}, changed flag.
  - Combinational; the state is held in the parent.

## Test plan
- Reset, target H = +0x0100, step 0x40, four vblank edges. Expected sf writes per frame:
  - addr1 0x80 / addr2 0x40
  - 0x80 / 0x80
  - 0x80 / 0xC0
  - 0x81 / 0x00
  - Fifth frame: no writes.
- Current H = +0x0020, target −0x0020, step 0x30. Expected:
  - Frame 1: dir 0, spd 0x0010 (addr1 0x00, addr2 0x10).
  - Frame 2: spd 0x0020.
- Snap = 1, target V = +0x7FFF. One frame gives addr3 0xFF, addr4 0xFF, with addr1/2 untouched.
- CPU writes addr0 = 0x01 during WR_H2. sf_write carries addr0 0x01 exactly once, after the sequence completes; V writes are not corrupted.
- Hold = 1, then three vblank edges: no sf_write, busy stays 0. After hold is cleared, the next edge yields a single one-step update.
- rst_n pulsed low during WR_V1:
  - All outputs 0 within the same cycle; no addr4 write follows.
  - Next frame with zero targets: no writes.

Source files
------------

// File: rtl/starfield_pkg.sv
// starfield_pkg: shared address map, FSM states and velocity helpers for the starfield ramp controller
package starfield_pkg;
  localparam int VEL_W = 16;
  localparam logic [2:0] CPU_EN    = 3'd0;
  localparam logic [2:0] CPU_TH_HI = 3'd1;
  localparam logic [2:0] CPU_TH_LO = 3'd2;
  localparam logic [2:0] CPU_TV_HI = 3'd3;
  localparam logic [2:0] CPU_TV_LO = 3'd4;
  localparam logic [2:0] CPU_STEP  = 3'd5;
  localparam logic [2:0] CPU_CTRL  = 3'd6;
  localparam logic [2:0] SF_EN     = 3'd0;
  localparam logic [2:0] SF_H_HI   = 3'd1;
  localparam logic [2:0] SF_H_LO   = 3'd2;
  localparam logic [2:0] SF_V_HI   = 3'd3;
  localparam logic [2:0] SF_V_LO   = 3'd4;
  typedef enum logic [2:0] {S_IDLE, S_CALC, S_WR_H1, S_WR_H2, S_WR_V1, S_WR_V2} state_t;
  function automatic logic signed [VEL_W-1:0] to_vel(input logic [15:0] p);
    return p[15] ? $signed({1'b0, p[14:0]}) : -$signed({1'b0, p[14:0]});
  endfunction
endpackage

// File: rtl/starfield_axis_ramp.sv
// starfield_axis_ramp: one frame of velocity ramping for a single axis, plus port encoding
module starfield_axis_ramp
  import starfield_pkg::*;
(
  input  logic signed [VEL_W-1:0] target,
  input  logic signed [VEL_W-1:0] current,
  input  logic        [7:0]       step,
  input  logic                    snap,
  output logic signed [VEL_W-1:0] nxt,
  output logic        [15:0]      port,
  output logic                    changed
);
  logic signed [VEL_W:0] diff, mag, stp;
  logic [14:0] spd;
  always_comb begin
    diff = {target[VEL_W-1], target} - {current[VEL_W-1], current};
    mag = diff[VEL_W] ? -diff : diff;
    stp = $signed({9'd0, step});
    nxt = (snap || mag <= stp) ? target :
          diff[VEL_W] ? current - {8'd0, step} : current + {8'd0, step};
    spd = nxt[VEL_W-1] ? 15'(-nxt) : nxt[14:0];
    port = {~nxt[VEL_W-1], spd};
    changed = nxt != current;
  end
endmodule

// File: rtl/starfield_ramp_ctrl.sv
// starfield_ramp_ctrl: ramps H/V starfield velocities toward CPU targets once per frame
// and forwards CPU enable writes to the starfield register port.
module starfield_ramp_ctrl
  import starfield_pkg::*;
#(
  parameter logic [7:0] RAMP_RST = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblank,
  input  logic [2:0] cpu_addr,
  input  logic [7:0] cpu_data,
  input  logic       cpu_write,
  output logic [2:0] sf_addr,
  output logic [7:0] sf_data,
  output logic       sf_write,
  output logic       busy
);
  state_t state_q, state_d;
  logic vb_q, vb_d, tick_q, tick_d, pend_q, pend_d;
  logic en_pend_q, en_pend_d, hold_q, hold_d, snap_q, snap_d, chg_v_q, chg_v_d;
  logic [7:0] en_data_q, en_data_d, stage_h_q, stage_h_d, stage_v_q, stage_v_d, step_q, step_d;
  logic signed [VEL_W-1:0] tgt_h_q, tgt_h_d, tgt_v_q, tgt_v_d, cur_h_q, cur_h_d, cur_v_q, cur_v_d;
  logic [15:0] port_h_q, port_h_d, port_v_q, port_v_d;
  logic [2:0] sf_addr_q, sf_addr_d;
  logic [7:0] sf_data_q, sf_data_d;
  logic sf_write_q, sf_write_d;
  logic signed [VEL_W-1:0] nxt_h, nxt_v;
  logic [15:0] pnxt_h, pnxt_v, ph, pv;
  logic chg_h, chg_v, en_wr, en_any, en_issue, commit;

  starfield_axis_ramp u_h (
    .target(tgt_h_q), .current(cur_h_q), .step(step_q), .snap(snap_q),
    .nxt(nxt_h), .port(pnxt_h), .changed(chg_h)
  );
  starfield_axis_ramp u_v (
    .target(tgt_v_q), .current(cur_v_q), .step(step_q), .snap(snap_q),
    .nxt(nxt_v), .port(pnxt_v), .changed(chg_v)
  );

  always_comb begin
    vb_d = vblank;
    tick_d = vblank & ~vb_q;
    // Ticks outside IDLE are merged into one pending frame; hold drops them entirely.
    pend_d = ~hold_q & (state_q != S_IDLE) & (pend_q | tick_q);
    stage_h_d = (cpu_write && cpu_addr == CPU_TH_HI) ? cpu_data : stage_h_q;
    stage_v_d = (cpu_write && cpu_addr == CPU_TV_HI) ? cpu_data : stage_v_q;
    tgt_h_d = (cpu_write && cpu_addr == CPU_TH_LO) ? to_vel({stage_h_q, cpu_data}) : tgt_h_q;
    tgt_v_d = (cpu_write && cpu_addr == CPU_TV_LO) ? to_vel({stage_v_q, cpu_data}) : tgt_v_q;
    step_d = (cpu_write && cpu_addr == CPU_STEP) ? cpu_data : step_q;
    hold_d = (cpu_write && cpu_addr == CPU_CTRL) ? cpu_data[0] : hold_q;
    snap_d = (cpu_write && cpu_addr == CPU_CTRL) ? cpu_data[1] : snap_q;
    en_wr = cpu_write && cpu_addr == CPU_EN;
    en_any = en_pend_q | en_wr;
    en_data_d = en_wr ? cpu_data : en_data_q;
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = ((tick_q | pend_q) && !hold_q) ? S_CALC : S_IDLE;
      S_CALC:  state_d = (en_any && (chg_h || chg_v)) ? S_CALC :
                         chg_h ? S_WR_H1 : chg_v ? S_WR_V1 : S_IDLE;
      S_WR_H1: state_d = S_WR_H2;
      S_WR_H2: state_d = chg_v_q ? S_WR_V1 : S_IDLE;
      S_WR_V1: state_d = S_WR_V2;
      S_WR_V2: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The ramp is committed once, on the cycle CALC is left, so a stall cannot double-step.
    commit = state_q == S_CALC && state_d != S_CALC;
    cur_h_d = commit ? nxt_h : cur_h_q;
    cur_v_d = commit ? nxt_v : cur_v_q;
    port_h_d = commit ? pnxt_h : port_h_q;
    port_v_d = commit ? pnxt_v : port_v_q;
    chg_v_d = commit ? chg_v : chg_v_q;
    ph = (state_q == S_CALC) ? pnxt_h : port_h_q;
    pv = (state_q == S_CALC) ? pnxt_v : port_v_q;
    en_issue = en_any && (state_d == S_IDLE || state_d == S_CALC);
    en_pend_d = en_any & ~en_issue;
    sf_write_d = en_issue || (state_d inside {S_WR_H1, S_WR_H2, S_WR_V1, S_WR_V2});
    sf_addr_d = en_issue ? SF_EN : state_d == S_WR_H1 ? SF_H_HI : state_d == S_WR_H2 ? SF_H_LO :
                state_d == S_WR_V1 ? SF_V_HI : state_d == S_WR_V2 ? SF_V_LO : 3'd0;
    sf_data_d = en_issue ? en_data_d : state_d == S_WR_H1 ? ph[15:8] : state_d == S_WR_H2 ? ph[7:0] :
                state_d == S_WR_V1 ? pv[15:8] : state_d == S_WR_V2 ? pv[7:0] : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vb_q <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
      en_pend_q <= 1'b0;
      en_data_q <= 8'd0;
      hold_q <= 1'b0;
      snap_q <= 1'b0;
      chg_v_q <= 1'b0;
      stage_h_q <= 8'd0;
      stage_v_q <= 8'd0;
      step_q <= RAMP_RST;
      tgt_h_q <= '0;
      tgt_v_q <= '0;
      cur_h_q <= '0;
      cur_v_q <= '0;
      port_h_q <= 16'd0;
      port_v_q <= 16'd0;
      sf_addr_q <= 3'd0;
      sf_data_q <= 8'd0;
      sf_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vb_q <= vb_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      en_pend_q <= en_pend_d;
      en_data_q <= en_data_d;
      hold_q <= hold_d;
      snap_q <= snap_d;
      chg_v_q <= chg_v_d;
      stage_h_q <= stage_h_d;
      stage_v_q <= stage_v_d;
      step_q <= step_d;
      tgt_h_q <= tgt_h_d;
      tgt_v_q <= tgt_v_d;
      cur_h_q <= cur_h_d;
      cur_v_q <= cur_v_d;
      port_h_q <= port_h_d;
      port_v_q <= port_v_d;
      sf_addr_q <= sf_addr_d;
      sf_data_q <= sf_data_d;
      sf_write_q <= sf_write_d;
    end
  end

  assign sf_addr = sf_addr_q;
  assign sf_data = sf_data_q;
  assign sf_write = sf_write_q;
  assign busy = state_q != S_IDLE;
endmodule
